// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller.
package pipe_ctrl_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam int unsigned INST_ADDR_LENGTH = 16;
  localparam logic [INST_ADDR_LENGTH-1:0] ZERO16 = '0;

  // Bit positions inside the per-stage stall vector.
  localparam int unsigned STG_PC  = 5;
  localparam int unsigned STG_IF  = 4;
  localparam int unsigned STG_ID  = 3;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 0;

  typedef enum logic [1:0] {
    PcsIdle     = 2'd0,
    PcsMulti    = 2'd1,
    PcsIntDrain = 2'd2,
    PcsIntRedir = 2'd3
  } pcs_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the datapath (master) and the pipeline controller (slave).
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
();

  logic                        stallreqId_i;
  logic                        stallreqEx_i;
  logic [3:0]                  exCycles_i;
  logic                        stallreqMem_i;
  logic                        branchFlag_i;
  logic [INST_ADDR_LENGTH-1:0] branchAddr_i;
  logic                        intReq_i;
  logic [INST_ADDR_LENGTH-1:0] pcId_i;

  logic [5:0]                  stall_o;
  logic                        flush_o;
  logic                        pcNewFlag_o;
  logic [INST_ADDR_LENGTH-1:0] pcNew_o;
  logic [INST_ADDR_LENGTH-1:0] epc_o;
  logic                        intAck_o;

  modport master (
    output stallreqId_i, stallreqEx_i, exCycles_i, stallreqMem_i,
    output branchFlag_i, branchAddr_i, intReq_i, pcId_i,
    input  stall_o, flush_o, pcNewFlag_o, pcNew_o, epc_o, intAck_o
  );

  modport slave (
    input  stallreqId_i, stallreqEx_i, exCycles_i, stallreqMem_i,
    input  branchFlag_i, branchAddr_i, intReq_i, pcId_i,
    output stall_o, flush_o, pcNewFlag_o, pcNew_o, epc_o, intAck_o
  );

endinterface

// File: rtl/pipe_ctrl_stall_prefix.sv
// Folds the three stall source levels into a monotone prefix vector:
// a hold at stage k always holds every earlier stage as well.
module pipe_ctrl_stall_prefix
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_i,
  input  logic       ex_i,
  input  logic       id_i,
  output logic [5:0] stall_o
);

  // Each stage holds if its own source or any later-stage source is active.
  always_comb begin
    stall_o          = '0;
    stall_o[STG_WB]  = 1'b0;
    stall_o[STG_MEM] = mem_i;
    stall_o[STG_EX]  = mem_i | ex_i;
    stall_o[STG_ID]  = mem_i | ex_i | id_i;
    stall_o[STG_IF]  = mem_i | ex_i | id_i;
    stall_o[STG_PC]  = mem_i | ex_i | id_i;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, sequences multi-cycle EX ops
// and interrupt entry, and drives the PC redirect.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [INST_ADDR_LENGTH-1:0] INT_VECTOR   = 16'h0008,
  parameter int unsigned                 DRAIN_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  pipe_ctrl_if.slave  bus
);

  pcs_state_e                  state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [INST_ADDR_LENGTH-1:0] epc_q, epc_d;

  logic       active;
  logic       ex_accept;
  logic       lvl_mem, lvl_ex, lvl_id;
  logic       branch_ok;
  logic [5:0] stall;

  // Outputs are forced quiet while reset is asserted.
  assign active = (rst_i != RST_ENABLE);

  // Stall source levels; an EX request with zero cycles is not a request.
  always_comb begin
    ex_accept = active && (state_q == PcsIdle) && bus.stallreqEx_i &&
                (bus.exCycles_i != 4'd0);
    lvl_mem   = active && bus.stallreqMem_i;
    lvl_ex    = active && ((state_q == PcsMulti) || ex_accept);
    lvl_id    = active && (bus.stallreqId_i || (state_q == PcsIntDrain));
  end

  pipe_ctrl_stall_prefix u_stall_prefix (
    .mem_i   (lvl_mem),
    .ex_i    (lvl_ex),
    .id_i    (lvl_id),
    .stall_o (stall)
  );

  // Redirect, flush and acknowledge; interrupt redirect beats any branch.
  always_comb begin
    branch_ok       = active && bus.branchFlag_i && !stall[STG_EX];
    bus.stall_o     = stall;
    bus.flush_o     = 1'b0;
    bus.pcNewFlag_o = 1'b0;
    bus.pcNew_o     = ZERO16;
    bus.intAck_o    = 1'b0;
    unique case (state_q)
      PcsIntRedir: begin
        bus.flush_o     = active;
        bus.pcNewFlag_o = active;
        bus.pcNew_o     = active ? INT_VECTOR : ZERO16;
        bus.intAck_o    = active;
      end
      PcsIntDrain: begin
        // Branch during drain only retargets the return address.
        bus.flush_o = branch_ok;
      end
      PcsIdle, PcsMulti: begin
        bus.flush_o     = branch_ok;
        bus.pcNewFlag_o = branch_ok;
        bus.pcNew_o     = branch_ok ? bus.branchAddr_i : ZERO16;
      end
    endcase
  end

  assign bus.epc_o = epc_q;

  // Next-state, counter and return-address capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    unique case (state_q)
      PcsIdle: begin
        if (ex_accept) begin
          // N = 1 stalls only this cycle and stays idle.
          if (bus.exCycles_i >= 4'd2) begin
            state_d = PcsMulti;
            cnt_d   = bus.exCycles_i - 4'd2;
          end
        end else if (bus.intReq_i && !branch_ok) begin
          state_d = PcsIntDrain;
          cnt_d   = 4'(DRAIN_CYCLES - 1);
          epc_d   = bus.pcId_i;
        end
      end
      PcsMulti: begin
        // Counts regardless of a MEM stall.
        if (cnt_q == 4'd0) begin
          state_d = PcsIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      PcsIntDrain: begin
        if (branch_ok) begin
          epc_d = bus.branchAddr_i;
        end
        // A MEM stall freezes the drain.
        if (!bus.stallreqMem_i) begin
          if (cnt_q == 4'd0) begin
            state_d = PcsIntRedir;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      PcsIntRedir: begin
        state_d = PcsIdle;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i == RST_ENABLE) begin
      state_q <= PcsIdle;
      cnt_q   <= 4'd0;
      epc_q   <= ZERO16;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
    end
  end

endmodule
